// File: rtl/galois_pow_dinv_ctrl.sv
// rtl/galois_pow_dinv_ctrl.sv - single-job sequencer between a request channel and the d-inverse power unit
// Define GALOIS_POW_TIMEOUT_EN to add the WAIT-state watchdog (TIMEOUT_CYCLES).
module galois_pow_dinv_ctrl #(
  parameter int N_BITS         = 254,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_base,
  input  logic [N_BITS-1:0] in_base1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_result,
  output logic [N_BITS-1:0] out_result1,
  output logic              out_error,
  output logic              pow_reset,
  output logic              pow_enable,
  output logic [N_BITS-1:0] pow_base,
  output logic [N_BITS-1:0] pow_base1,
  input  logic [N_BITS-1:0] pow_result,
  input  logic [N_BITS-1:0] pow_result1,
  input  logic              pow_done,
  output logic [15:0]       jobs_done
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

  state_t state, state_d;
  logic   accept;
  logic   wd_expire;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // pow_reset doubles as the "first edge after reset not yet seen" flag gating in_ready.
  always_comb begin
    state_d    = state;
    in_ready   = 1'b0;
    pow_enable = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = ~pow_reset;
        if (in_valid && ~pow_reset) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        pow_enable = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (pow_done || wd_expire) state_d = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pow_reset   <= 1'b1;
      pow_base    <= '0;
      pow_base1   <= '0;
      out_result  <= '0;
      out_result1 <= '0;
      jobs_done   <= '0;
    end else begin
      pow_reset <= 1'b0;
      if (accept) begin
        pow_base  <= in_base;
        pow_base1 <= in_base1;
      end
      if (state == S_WAIT) begin
        if (pow_done) begin
          out_result  <= pow_result;
          out_result1 <= pow_result1;
        end else if (wd_expire) begin
          out_result  <= '0;
          out_result1 <= '0;
        end
      end
      if (state == S_HOLD && out_ready) jobs_done <= jobs_done + 16'd1;
    end
  end

`ifdef GALOIS_POW_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Counter holds the number of WAIT cycles already elapsed; expiry fires in the last allowed one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                wd_cnt <= '0;
    else if (state == S_LAUNCH)  wd_cnt <= '0;
    else if (state == S_WAIT)    wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expire = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_error <= 1'b0;
    end else if (state == S_WAIT) begin
      if (pow_done)       out_error <= 1'b0;
      else if (wd_expire) out_error <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign out_error = 1'b0;
`endif

endmodule

// File: tb/tb_galois_pow_dinv_ctrl.sv
// tb/tb_galois_pow_dinv_ctrl.sv - self-checking bench for galois_pow_dinv_ctrl with power-unit model and scoreboard
module tb_galois_pow_dinv_ctrl;
  localparam int NB = 254;
`ifdef GALOIS_POW_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          pow_done = 1'b0;
  logic          in_ready, out_valid, out_error, pow_reset, pow_enable;
  logic [NB-1:0] in_base = '0, in_base1 = '0;
  logic [NB-1:0] out_result, out_result1, pow_base, pow_base1;
  logic [NB-1:0] pow_result = '0, pow_result1 = '0;
  logic [15:0]   jobs_done;

  always #5 clk = ~clk;

  galois_pow_dinv_ctrl #(.N_BITS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_base(in_base), .in_base1(in_base1),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_result1(out_result1), .out_error(out_error),
    .pow_reset(pow_reset), .pow_enable(pow_enable), .pow_base(pow_base), .pow_base1(pow_base1),
    .pow_result(pow_result), .pow_result1(pow_result1), .pow_done(pow_done),
    .jobs_done(jobs_done)
  );

  typedef struct { logic [NB-1:0] res; logic [NB-1:0] res1; logic err; } exp_t;
  typedef struct { logic [NB-1:0] base; logic [NB-1:0] base1; int lat; logic [NB-1:0] res; logic [NB-1:0] res1; } vec_t;

  exp_t          sb[$];
  int            lat_q[$];
  vec_t          vecs[6];
  int            n_cmp = 0, n_bad = 0, n_resp = 0, cyc = 0;
  int            enable_pulses = 0, enable_cyc = -1, done_cyc = -1, valid_rise_cyc = -1, accept_cyc = -1;
  int            base_viol = 0, pow_cnt = 0;
  bit            pow_busy = 1'b0, prev_valid = 1'b0;
  logic [15:0]   exp_jobs = '0;
  logic [NB-1:0] cap_base = '0, cap_base1 = '0;

  // Stand-in for the d-th root: the controller only forwards it, so any fixed mapping works.
  function automatic logic [NB-1:0] model_root(input logic [NB-1:0] b);
    return (b * NB'(64'h9E37_79B9_7F4A_7C15)) ^ NB'(64'h0000_0000_DEAD_BEEF);
  endfunction

  function automatic logic [NB-1:0] model_pow(input logic [NB-1:0] b, input logic [NB-1:0] b1);
    logic [NB-1:0] r;
    r = NB'(1);
    for (int i = 0; i < int'(b[7:0]); i++) r = r * b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Power-unit model: latency per job comes from lat_q; a negative latency never answers.
  always @(negedge clk) begin
    pow_done = 1'b0;
    if (!reset_n) begin
      pow_busy = 1'b0;
    end else if (pow_enable) begin
      enable_pulses++;
      enable_cyc = cyc;
      cap_base   = pow_base;
      cap_base1  = pow_base1;
      pow_cnt    = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
      pow_busy   = (pow_cnt > 0);
    end else if (pow_busy) begin
      pow_cnt--;
      if (pow_cnt <= 0) begin
        pow_done    = 1'b1;
        pow_result  = model_root(cap_base);
        pow_result1 = model_pow(cap_base, cap_base1);
        pow_busy    = 1'b0;
        done_cyc    = cyc;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset_n) begin
      if (out_valid && !prev_valid) valid_rise_cyc = cyc;
      if (pow_busy && (pow_base !== cap_base || pow_base1 !== cap_base1)) base_viol++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_response: got result %0h, required no response", out_result);
        end else begin
          e = sb.pop_front();
          check("out_result", out_result, e.res);
          check("out_result1", out_result1, e.res1);
          check("out_error", out_error, e.err);
          n_resp++;
          exp_jobs++;
        end
      end
    end
    prev_valid = reset_n && out_valid;
  end

  task automatic send(input logic [NB-1:0] b, input logic [NB-1:0] b1, input int lat,
                      input logic [NB-1:0] r, input logic [NB-1:0] r1, input logic err, input bit keep);
    exp_t e;
    int   k;
    in_base  = b;
    in_base1 = b1;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 10000) begin
      @(negedge clk);
      k++;
    end
    check("accept", in_ready, 1);
    if (in_ready) begin
      e.res = r; e.res1 = r1; e.err = err;
      sb.push_back(e);
      lat_q.push_back(lat);
      accept_cyc = cyc;
    end
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int k;
    k = 0;
    while (n_resp < target && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("resp_wait", n_resp >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] r, r1;
    logic          er;
    int            p0, r0, viol, k;
    logic [15:0]   jd0;

    vecs[0] = '{base: NB'(3),  base1: NB'(7), lat: 1,  res: '0, res1: '0};
    vecs[1] = '{base: NB'(1),  base1: NB'(9), lat: 2,  res: '0, res1: '0};
    vecs[2] = '{base: NB'(0),  base1: NB'(5), lat: 7,  res: '0, res1: '0};
    vecs[3] = '{base: NB'(12), base1: NB'(2), lat: 3,  res: '0, res1: '0};
    vecs[4] = '{base: '1,      base1: NB'(3), lat: 1,  res: '0, res1: '0};
    vecs[5] = '{base: NB'(31), base1: NB'(3), lat: 12, res: '0, res1: '0};
    foreach (vecs[i]) begin
      vecs[i].res  = model_root(vecs[i].base);
      vecs[i].res1 = model_pow(vecs[i].base, vecs[i].base1);
    end

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_pow_enable", pow_enable, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_error", out_error, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_result1", out_result1, 0);
    check("rst_pow_base", pow_base, 0);
    check("rst_pow_base1", pow_base1, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_pow_reset", pow_reset, 1);

    reset_n = 1'b1;
    #1;
    check("release_in_ready_before_edge", in_ready, 0);
    check("release_pow_reset_before_edge", pow_reset, 1);
    @(negedge clk);
    check("release_in_ready_after_edge", in_ready, 1);
    check("release_pow_reset_after_edge", pow_reset, 0);

    // Single long job, accepted on the very first ready cycle.
    out_ready = 1'b1;
    p0 = enable_pulses;
    send(NB'(5), NB'(2), 3302, model_root(NB'(5)), NB'(32), 1'b0, 1'b0);
    wait_resp(1);
    @(negedge clk);
    check("single_enable_pulses", enable_pulses - p0, 1);
    check("req_latency", enable_cyc, accept_cyc + 1);
    check("resp_latency", valid_rise_cyc, done_cyc + 1);
    check("result1_is_32", out_result1, 32);
    check("jobs_done_first", jobs_done, 1);

    // Back-pressure in HOLD with a competing request.
    out_ready = 1'b0;
    send(NB'(7), NB'(3), 4, model_root(NB'(7)), model_pow(NB'(7), NB'(3)), 1'b0, 1'b0);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("hold_reached", out_valid, 1);
    r = out_result; r1 = out_result1; er = out_error;
    p0 = enable_pulses;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_base  = NB'(99);
      in_base1 = NB'(98);
      @(negedge clk);
      if (!out_valid || out_result !== r || out_result1 !== r1 || out_error !== er || in_ready) viol++;
    end
    check("hold_stable_violations", viol, 0);
    check("hold_no_second_accept", enable_pulses - p0, 0);
    check("hold_pow_base_kept", pow_base, 7);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_resp(2);
    @(negedge clk);
    check("jobs_done_after_hold", jobs_done, 2);

    // Back-to-back table jobs with in_valid held high.
    p0 = enable_pulses;
    r0 = n_resp;
    jd0 = jobs_done;
    base_viol = 0;
    foreach (vecs[i]) send(vecs[i].base, vecs[i].base1, vecs[i].lat, vecs[i].res, vecs[i].res1, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_resp(r0 + 6);
    @(negedge clk);
    check("b2b_enable_pulses", enable_pulses - p0, 6);
    check("b2b_pow_base_stable", base_viol, 0);
    check("b2b_jobs_done", jobs_done, 16'(jd0 + 16'd6));

    // Reset while the unit is mid-WAIT.
    send(NB'(9), NB'(4), 50, model_root(NB'(9)), model_pow(NB'(9), NB'(4)), 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    r0 = n_resp;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_pow_enable", pow_enable, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_out_result1", out_result1, 0);
    check("midrst_pow_base", pow_base, 0);
    check("midrst_pow_reset", pow_reset, 1);
    check("midrst_jobs_done", jobs_done, 0);
    void'(sb.pop_back());
    exp_jobs = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_response", n_resp, r0);
    check("midrst_jobs_done_after", jobs_done, 0);
    send(NB'(6), NB'(3), 5, model_root(NB'(6)), model_pow(NB'(6), NB'(3)), 1'b0, 1'b0);
    wait_resp(r0 + 1);
    @(negedge clk);
    check("midrst_next_job_count", jobs_done, 1);

    // Counter wrap.
    force dut.jobs_done = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_done;
    exp_jobs = 16'hFFFF;
    check("jobs_done_forced", jobs_done, 16'hFFFF);
    r0 = n_resp;
    send(NB'(2), NB'(2), 3, model_root(NB'(2)), NB'(4), 1'b0, 1'b0);
    wait_resp(r0 + 1);
    @(negedge clk);
    check("jobs_done_wrap", jobs_done, 0);

`ifdef GALOIS_POW_TIMEOUT_EN
    r0 = n_resp;
    send(NB'(11), NB'(5), -1, '0, '0, 1'b1, 1'b0);
    wait_resp(r0 + 1);
    check("timeout_latency", valid_rise_cyc, enable_cyc + 17);
    send(NB'(13), NB'(2), 16, model_root(NB'(13)), model_pow(NB'(13), NB'(2)), 1'b0, 1'b0);
    wait_resp(r0 + 2);
    check("done_on_expiry_latency", valid_rise_cyc, enable_cyc + 17);
    send(NB'(4), NB'(3), 20, '0, '0, 1'b1, 1'b0);
    wait_resp(r0 + 3);
    repeat (10) @(negedge clk);
    check("late_done_no_response", n_resp, r0 + 3);
    check("late_done_result_kept", out_result, 0);
    check("late_done_idle", in_ready, 1);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/galois_pow_dinv_ctrl.md
GALOIS_POW_DINV_CTRL -- requirements
Module: galois_pow_dinv_ctrl

Interface
REQ-001 SHALL take parameter N_BITS, default 254, as the field element width.
REQ-002 SHALL take parameter TIMEOUT_CYCLES, default 4096, as the max WAIT-state cycles before abort; it is used only with GALOIS_POW_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1, the single clock for the block.
REQ-004 SHALL have port reset_n, input, 1, the reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_base (in, N_BITS) and in_base1 (in, N_BITS) as the job request channel.
REQ-006 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_result (out, N_BITS), out_result1 (out, N_BITS) and out_error (out, 1) as the job response channel.
REQ-007 SHALL have ports pow_reset (out, 1), pow_enable (out, 1), pow_base (out, N_BITS) and pow_base1 (out, N_BITS) as the drive side to the d-inverse power unit.
REQ-008 SHALL have ports pow_result (in, N_BITS), pow_result1 (in, N_BITS) and pow_done (in, 1) as the return side from the d-inverse power unit.
REQ-009 SHALL have port jobs_done, output, 16, the count of completed responses.

Function
REQ-010 SHALL implement FSM states IDLE, LAUNCH, WAIT and HOLD; a state encoding outside these SHALL go to IDLE.
REQ-011 IDLE: SHALL drive in_ready=1; on in_valid&&in_ready it SHALL register in_base/in_base1 into pow_base/pow_base1 and go to LAUNCH.
REQ-012 LAUNCH: SHALL drive pow_enable=1 for exactly one cycle, then go to WAIT; pow_done in LAUNCH SHALL be ignored.
REQ-013 pow_enable SHALL be 0 in every state other than LAUNCH.
REQ-014 pow_base/pow_base1 SHALL be held stable from capture until the next IDLE capture, including through WAIT and HOLD.
REQ-015 WAIT: on pow_done=1, SHALL register pow_result into out_result, pow_result1 into out_result1, set out_error=0 and go to HOLD.
REQ-016 HOLD: SHALL drive out_valid=1 with out_result, out_result1 and out_error stable; on out_ready=1 it SHALL increment jobs_done and go to IDLE.
REQ-017 in_ready SHALL be 0 in LAUNCH, WAIT and HOLD, so at most one job is in flight.
REQ-018 out_valid SHALL be 0 outside HOLD.
REQ-019 Response latency SHALL be pow_done arrival + 1 cycle to out_valid; request latency SHALL be 1 cycle from accept to pow_enable.
REQ-020 jobs_done SHALL wrap from 16'hFFFF to 0.
REQ-021 After deassertion of reset_n, a job accepted in the same cycle that in_valid first rises SHALL be handled normally.

Reset
REQ-022 While reset_n=0 the block SHALL be in IDLE with in_ready=0, pow_enable=0, out_valid=0, out_error=0, out_result=0, out_result1=0, pow_base=0, pow_base1=0 and jobs_done=0.
REQ-023 in_ready SHALL go to 1 on the first clk edge after reset_n release.
REQ-024 pow_reset SHALL assert asynchronously with reset_n=0 and deassert on the first clk edge after reset_n rises, so the power unit is in INIT when IDLE resumes.
REQ-025 Reset mid-job (LAUNCH, WAIT or HOLD) SHALL discard the job with no response and no jobs_done increment.

Configuration
REQ-026 Macro GALOIS_POW_TIMEOUT_EN SHALL control the WAIT-state watchdog.
REQ-027 With GALOIS_POW_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without pow_done the block SHALL go to HOLD with out_error=1, out_result=0 and out_result1=0.
REQ-028 With GALOIS_POW_TIMEOUT_EN defined: if pow_done coincides with the expiry cycle, pow_done SHALL win and out_error SHALL be 0.
REQ-029 With GALOIS_POW_TIMEOUT_EN defined: a late pow_done arriving after a timeout SHALL be ignored outside WAIT.
REQ-030 Without GALOIS_POW_TIMEOUT_EN: WAIT SHALL last indefinitely, out_error SHALL be tied 0, and no counter logic SHALL be instantiated.

Verification
REQ-031 Reset then single job in_base=5, in_base1=2 with a power-unit model returning done after 3302 cycles: one pow_enable pulse, out_result=5^(1/5) mod p, out_result1=2^5=32, out_error=0, jobs_done=1.
REQ-032 Hold out_ready=0 for 20 cycles in HOLD: out_valid stays 1, outputs are unchanged, in_ready stays 0, and a second in_valid is not accepted.
REQ-033 Back-to-back jobs with out_ready=1 and in_valid=1: exactly one pow_enable per job, pow_base is unchanged during WAIT, and jobs_done increments per response.
REQ-034 With GALOIS_POW_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 and no pow_done: out_valid after 16 WAIT cycles with out_error=1 and results 0; pow_done on cycle 16 instead yields out_error=0.
REQ-035 Assert reset_n=0 in mid-WAIT: all outputs go to 0 immediately, pow_reset=1, jobs_done is unchanged at 0 afterward, and the next job completes correctly.
REQ-036 Force jobs_done to 16'hFFFF and complete one job: jobs_done becomes 0.
